// File: rtl/ibex_pkg.sv
// Shared types for the multiply/divide sequencer: operation and state encodings,
// datapath widths and the final sign-correction helper.
package ibex_pkg;

    localparam int unsigned MD_W     = 32;
    localparam int unsigned MD_CNT_W = 5;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PREP   = 2'b01,
        ITER   = 2'b10,
        FINISH = 2'b11
    } md_seq_state_e;

    // acc holds the 64-bit magnitude product, or {remainder, quotient} for divides
    function automatic logic [MD_W-1:0] md_result(
        input md_op_e            op,
        input logic [2*MD_W-1:0] acc,
        input logic              neg_a,
        input logic              neg_b,
        input logic              b_zero,
        input logic [MD_W-1:0]   op_a
    );
        logic [2*MD_W-1:0] prod;
        logic [MD_W-1:0]   quo;
        logic [MD_W-1:0]   rem;
        prod = (neg_a ^ neg_b) ? -acc : acc;
        quo  = acc[MD_W-1:0];
        rem  = acc[2*MD_W-1:MD_W];
        case (op)
            MD_OP_MULL: md_result = prod[MD_W-1:0];
            MD_OP_MULH: md_result = prod[2*MD_W-1:MD_W];
            MD_OP_DIV:  md_result = b_zero ? '1   : ((neg_a ^ neg_b) ? -quo : quo);
            default:    md_result = b_zero ? op_a : (neg_a ? -rem : rem);
        endcase
    endfunction

endpackage

// File: rtl/ibex_md_seq.sv
// Iterative radix-2 multiply/divide sequencer (IDLE -> PREP -> ITER -> FINISH).
// Define IBEX_MD_ZERO_DIV_BYPASS_EN to skip the iterations on a zero divisor.
module ibex_md_seq
    import ibex_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            md_req_i,
    output logic            md_ready_o,
    input  md_op_e          md_op_i,
    input  logic            signed_a_i,
    input  logic            signed_b_i,
    input  logic [MD_W-1:0] op_a_i,
    input  logic [MD_W-1:0] op_b_i,
    input  logic            kill_i,
    output logic            md_valid_o,
    input  logic            result_ready_i,
    output logic [MD_W-1:0] md_result_o
);

    md_seq_state_e       state_q, state_d;
    md_op_e              op_q, op_d;
    logic                signed_a_q, signed_a_d;
    logic                signed_b_q, signed_b_d;
    logic [MD_W-1:0]     op_a_q, op_a_d;
    logic [MD_W-1:0]     op_b_q, op_b_d;
    logic [MD_W-1:0]     abs_a_q, abs_a_d;
    logic [MD_W-1:0]     abs_b_q, abs_b_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_b_q, neg_b_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic [2*MD_W-1:0]   acc_q, acc_d;
    logic [MD_W-1:0]     result_q, result_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;

    logic                is_div;
    logic [MD_W:0]       rem_shift;
    logic [MD_W:0]       rem_diff;
    logic                rem_ge;
    logic [2*MD_W-1:0]   mul_step;
    logic [2*MD_W-1:0]   div_step;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        signed_a_d = signed_a_q;
        signed_b_d = signed_b_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        abs_a_d    = abs_a_q;
        abs_b_d    = abs_b_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        result_d   = result_q;

        is_div    = (op_q == MD_OP_DIV) || (op_q == MD_OP_REM);
        // MSB-first steps: the multiplier bit / next dividend bit is selected by the counter
        rem_shift = {acc_q[2*MD_W-1:MD_W], abs_a_q[cnt_q]};
        rem_diff  = rem_shift - {1'b0, abs_b_q};
        rem_ge    = (rem_shift >= {1'b0, abs_b_q});
        mul_step  = {acc_q[2*MD_W-2:0], 1'b0}
                  + (abs_b_q[cnt_q] ? {{MD_W{1'b0}}, abs_a_q} : {(2*MD_W){1'b0}});
        div_step  = rem_ge ? {rem_diff[MD_W-1:0],  acc_q[MD_W-2:0], 1'b1}
                           : {rem_shift[MD_W-1:0], acc_q[MD_W-2:0], 1'b0};

        case (state_q)
            IDLE: begin
                if (md_req_i && ready_q && !kill_i) begin
                    op_d       = md_op_i;
                    signed_a_d = signed_a_i;
                    signed_b_d = signed_b_i;
                    op_a_d     = op_a_i;
                    op_b_d     = op_b_i;
                    state_d    = PREP;
                end
            end
            PREP: begin
                neg_a_d = signed_a_q & op_a_q[MD_W-1];
                neg_b_d = signed_b_q & op_b_q[MD_W-1];
                abs_a_d = (signed_a_q & op_a_q[MD_W-1]) ? -op_a_q : op_a_q;
                abs_b_d = (signed_b_q & op_b_q[MD_W-1]) ? -op_b_q : op_b_q;
                cnt_d   = MD_CNT_W'(MD_W - 1);
                acc_d   = '0;
                state_d = ITER;
`ifdef IBEX_MD_ZERO_DIV_BYPASS_EN
                if (is_div && (op_b_q == '0)) begin
                    cnt_d    = '0;
                    result_d = (op_q == MD_OP_DIV) ? '1 : op_a_q;
                    state_d  = FINISH;
                end
`endif
            end
            ITER: begin
                acc_d = is_div ? div_step : mul_step;
                if (cnt_q == '0) begin
                    result_d = md_result(op_q, acc_d, neg_a_q, neg_b_q,
                                         (abs_b_q == '0), op_a_q);
                    state_d  = FINISH;
                end else begin
                    cnt_d = cnt_q - MD_CNT_W'(1);
                end
            end
            FINISH: begin
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything and leaves the last delivered result untouched
        if (kill_i) begin
            state_d  = IDLE;
            result_d = result_q;
        end

        valid_d = (state_d == FINISH);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            op_q       <= MD_OP_MULL;
            signed_a_q <= 1'b0;
            signed_b_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            abs_a_q    <= '0;
            abs_b_q    <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            signed_a_q <= signed_a_d;
            signed_b_q <= signed_b_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            abs_a_q    <= abs_a_d;
            abs_b_q    <= abs_b_d;
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
        end
    end

    assign md_ready_o  = ready_q;
    assign md_valid_o  = valid_q;
    assign md_result_o = result_q;

endmodule

// File: tb/tb_ibex_md_seq.sv
// Directed self-checking bench for ibex_md_seq with hand-computed results.
module tb_ibex_md_seq;
    import ibex_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        md_req;
    logic        md_ready;
    md_op_e      md_op;
    logic        signed_a;
    logic        signed_b;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        kill;
    logic        md_valid;
    logic        result_ready;
    logic [31:0] md_result;

    int vecs;
    int errs;
    int div0_lat;

    ibex_md_seq dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .md_req_i       (md_req),
        .md_ready_o     (md_ready),
        .md_op_i        (md_op),
        .signed_a_i     (signed_a),
        .signed_b_i     (signed_b),
        .op_a_i         (op_a),
        .op_b_i         (op_b),
        .kill_i         (kill),
        .md_valid_o     (md_valid),
        .result_ready_i (result_ready),
        .md_result_o    (md_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure latency, stall the consumer, then hand-shake
    task automatic do_op(input string tag, input md_op_e op, input logic sa, input logic sb,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input int stall);
        int lat;
        @(negedge clk);
        md_req = 1'b1; md_op = op; signed_a = sa; signed_b = sb; op_a = a; op_b = b;
        @(posedge clk); #1;
        md_req = 1'b0;
        op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D;
        chk({tag, " ready_after_accept"}, 32'(md_ready), 32'd0);
        lat = 1;
        while (!md_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, md_result, exp);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold_valid"}, 32'(md_valid), 32'd1);
            chk({tag, " hold_result"}, md_result, exp);
        end
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk({tag, " valid_after_hs"}, 32'(md_valid), 32'd0);
        chk({tag, " ready_after_hs"}, 32'(md_ready), 32'd1);
    endtask

    initial begin
        logic seen_valid;
        vecs = 0; errs = 0;
`ifdef IBEX_MD_ZERO_DIV_BYPASS_EN
        div0_lat = 2;
`else
        div0_lat = 34;
`endif
        rst_n = 1'b0; md_req = 1'b0; md_op = MD_OP_MULL; signed_a = 1'b0; signed_b = 1'b0;
        op_a = '0; op_b = '0; kill = 1'b0; result_ready = 1'b0;
        #12;
        chk("rst ready", 32'(md_ready), 32'd1);
        chk("rst valid", 32'(md_valid), 32'd0);
        chk("rst result", md_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("mull_s",   MD_OP_MULL, 1'b1, 1'b1, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 5);
        do_op("mulh_ss",  MD_OP_MULH, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
        do_op("mulh_uu",  MD_OP_MULH, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
        do_op("mulh_su",  MD_OP_MULH, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
        do_op("div_ovf",  MD_OP_DIV,  1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0);
        do_op("rem_ovf",  MD_OP_REM,  1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
        do_op("div_neg",  MD_OP_DIV,  1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 34, 0);
        do_op("rem_neg",  MD_OP_REM,  1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFFE, 34, 0);
        do_op("div_u",    MD_OP_DIV,  1'b0, 1'b0, 32'd1000,      32'd7,        32'd142,       34, 0);
        do_op("rem_u",    MD_OP_REM,  1'b0, 1'b0, 32'd1000,      32'd7,        32'd6,         34, 0);
        do_op("div_zero", MD_OP_DIV,  1'b0, 1'b0, 32'd100,       32'd0,        32'hFFFF_FFFF, div0_lat, 0);
        do_op("rem_zero", MD_OP_REM,  1'b0, 1'b0, 32'd100,       32'd0,        32'd100,       div0_lat, 2);
        do_op("remz_neg", MD_OP_REM,  1'b1, 1'b1, 32'hFFFF_FF9C, 32'd0,        32'hFFFF_FF9C, div0_lat, 0);

        // Kill during the tenth iteration cycle
        @(negedge clk);
        md_req = 1'b1; md_op = MD_OP_MULL; signed_a = 1'b0; signed_b = 1'b0;
        op_a = 32'h1234; op_b = 32'h10;
        @(posedge clk); #1;
        md_req = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill ready", 32'(md_ready), 32'd1);
        chk("kill valid", 32'(md_valid), 32'd0);
        chk("kill result_kept", md_result, 32'hFFFF_FF9C);
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen_valid |= md_valid;
        end
        chk("kill no_valid", 32'(seen_valid), 32'd0);
        do_op("mull_after_kill", MD_OP_MULL, 1'b0, 1'b0, 32'd3, 32'd5, 32'd15, 34, 0);

        // Kill together with a request in IDLE blocks the accept
        @(negedge clk);
        md_req = 1'b1; kill = 1'b1; md_op = MD_OP_MULL; op_a = 32'd2; op_b = 32'd2;
        @(posedge clk); #1;
        md_req = 1'b0; kill = 1'b0;
        chk("kill_req ready", 32'(md_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("kill_req still_idle", 32'(md_ready), 32'd1);
        chk("kill_req result", md_result, 32'd15);

        // Asynchronous reset in the middle of an iteration
        @(negedge clk);
        md_req = 1'b1; md_op = MD_OP_DIV; signed_a = 1'b0; signed_b = 1'b0;
        op_a = 32'd5000; op_b = 32'd3;
        @(posedge clk); #1;
        md_req = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst ready", 32'(md_ready), 32'd1);
        chk("arst valid", 32'(md_valid), 32'd0);
        chk("arst result", md_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("div_after_rst", MD_OP_DIV, 1'b0, 1'b0, 32'd5000, 32'd3, 32'd1666, 34, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ibex_md_seq.md
IBEX_MD_SEQ -- requirements
Module: ibex_md_seq

Interface
REQ-001 SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port md_req_i, input, 1 bit: operation request, valid-style.
REQ-005 SHALL have port md_ready_o, output, 1 bit: block idle and able to accept a request.
REQ-006 SHALL have port md_op_i, input, md_op_e: MULL, MULH, DIV or REM.
REQ-007 SHALL have ports signed_a_i and signed_b_i, input, 1 bit each: treat operand A or operand B as two's complement.
REQ-008 SHALL have ports op_a_i and op_b_i, input, 32 bits each: operands, sampled only on accept.
REQ-009 SHALL have port kill_i, input, 1 bit: abort any in-flight operation.
REQ-010 SHALL have port md_valid_o, output, 1 bit: result valid.
REQ-011 SHALL have port result_ready_i, input, 1 bit: consumer takes the result.
REQ-012 SHALL have port md_result_o, output, 32 bits: result, registered.

Function
REQ-013 SHALL implement the FSM IDLE -> PREP -> ITER -> FINISH -> IDLE.
REQ-014 SHALL drive md_ready_o=1 only in IDLE; accept means md_req_i & md_ready_o & ~kill_i.
REQ-015 On accept: latch operands, op and signedness, then go to PREP.
REQ-016 PREP (1 cycle): register |A| and |B| as unsigned 32-bit values (absolute value only where the operand's signed flag is set), register the result-sign flag, load counter=31.
REQ-017 ITER: one radix-2 step per cycle; shift-add for MULL/MULH, restoring subtract for DIV/REM; decrement the counter; leave ITER after the step with counter==0, i.e. 32 cycles.
REQ-018 FINISH: apply sign correction and drive md_result_o and md_valid_o=1; hold both stable until result_ready_i=1, then go to IDLE.
REQ-019 Sign correction, multiply: negate the 64-bit product if exactly one signed operand is negative; MULL returns [31:0], MULH returns [63:32].
REQ-020 Sign correction, divide: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
REQ-021 Overflow case 0x80000000 / 0xFFFFFFFF (signed) SHALL give quotient 0x80000000 and remainder 0.
REQ-022 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = op_a, with no sign correction.
REQ-023 Latency: accept in cycle N gives md_valid_o=1 in cycle N+34.
REQ-024 kill_i=1 in any state SHALL force IDLE next cycle with md_valid_o=0 and no result update; kill_i together with md_req_i in IDLE: kill wins and no accept occurs.
REQ-025 Back-to-back: a new accept is possible in the cycle after the FINISH handshake.

Reset
REQ-026 Asynchronous reset SHALL force IDLE, md_ready_o=1, md_valid_o=0, md_result_o=0, counter=0, all operand registers=0.
REQ-027 Reset asserted mid-operation SHALL discard the operation silently.

Configuration
REQ-028 With macro IBEX_MD_ZERO_DIV_BYPASS_EN defined, a zero divisor detected in PREP SHALL go straight to FINISH (md_valid_o at N+2) with the REQ-022 result.
REQ-029 With IBEX_MD_ZERO_DIV_BYPASS_EN undefined, divide by zero SHALL run the full 32 iterations (N+34) and override the result per REQ-022.

Structure
REQ-030 typedef md_seq_state_e (IDLE, PREP, ITER, FINISH; logic [1:0]) SHALL be added to ibex_pkg; md_op_e SHALL be reused from ibex_pkg.
REQ-031 SHALL be implemented as one module with no sub-module; controller and datapath are small enough to keep together.

Verification
REQ-032 MULL signed 7 x 0xFFFFFFFD -> md_result_o=0xFFFFFFEB, md_valid_o at accept+34.
REQ-033 MULH signed 0x80000000 x 0x80000000 -> 0x40000000; MULH unsigned 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-034 DIV signed 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0; DIV signed 0xFFFFFF9C (-100) / 7 -> 0xFFFFFFF2, REM -> 0xFFFFFFFE.
REQ-035 DIV 100/0 -> 0xFFFFFFFF and REM 100/0 -> 100; latency 34 with the macro undefined, 2 with it defined.
REQ-036 kill_i in ITER cycle 10 -> md_valid_o never rises and md_ready_o=1 next cycle; a new MULL 3x5 then returns 15.
REQ-037 result_ready_i=0 for 5 cycles in FINISH -> result held stable; rst_ni low mid-ITER -> all outputs at reset values immediately (asynchronous).
